// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: PCSEL encodings, FSM states, program map.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] PCSEL_INC   = 3'd0;
  localparam logic [SEL_W-1:0] PCSEL_BR    = 3'd1;
  localparam logic [SEL_W-1:0] PCSEL_JMP   = 3'd2;
  localparam logic [SEL_W-1:0] PCSEL_ILLOP = 3'd3;
  localparam logic [SEL_W-1:0] PCSEL_XADR  = 3'd4;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_LAUNCH = 2'd1,
    FS_RUN    = 2'd2,
    FS_DONE   = 2'd3
  } fs_state_e;

  // Program entry points; the ROM image is laid out against these.
  localparam logic [XLEN-1:0] BASE1     = 32'd80;
  localparam logic [XLEN-1:0] BASE2     = 32'd120;
  localparam logic [XLEN-1:0] BASE3     = 32'd320;
  localparam logic [XLEN-1:0] BASE4     = 32'd400;
  localparam logic [XLEN-1:0] ILLOP_VEC = 32'd508;
  localparam logic [XLEN-1:0] XADR_VEC  = 32'd504;

  // Program number to base address; invalid numbers map to 0.
  function automatic logic [XLEN-1:0] prog_base(input logic [SEL_W-1:0] sel);
    case (sel)
      3'd1:    prog_base = BASE1;
      3'd2:    prog_base = BASE2;
      3'd3:    prog_base = BASE3;
      3'd4:    prog_base = BASE4;
      default: prog_base = '0;
    endcase
  endfunction

  function automatic logic prog_valid(input logic [SEL_W-1:0] sel);
    prog_valid = (sel >= 3'd1) && (sel <= 3'd4);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Next-PC priority select with supervisor-bit handling; purely combinational.
module fetch_sequencer_pc_next_mux
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pcsel,
  input  logic [31:0] br_tgt,
  input  logic [31:0] jmp_tgt,
  input  logic        irq,
  output logic [31:0] next_pc_c,
  output logic        trap_c,
  output logic        complete_c
);

  // Interrupts only vector from user mode; branches may raise but never drop pc[31];
  // jumps may drop but never raise it; +4 is a plain modulo-2^32 add.
  always_comb begin
    next_pc_c  = pc + 32'd4;
    trap_c     = 1'b0;
    complete_c = 1'b0;
    if (irq && !pc[31]) begin
      next_pc_c = XADR_VEC;
      trap_c    = 1'b1;
    end else begin
      case (pcsel)
        PCSEL_ILLOP: begin
          next_pc_c = ILLOP_VEC;
          trap_c    = 1'b1;
        end
        PCSEL_JMP: begin
          next_pc_c  = {pc[31] & jmp_tgt[31], jmp_tgt[30:2], 2'b00};
          complete_c = (jmp_tgt[31:2] == 30'd0);
        end
        PCSEL_BR: begin
          next_pc_c = {pc[31] | br_tgt[31], br_tgt[30:0]};
        end
        PCSEL_XADR: begin
          next_pc_c = XADR_VEC;
          trap_c    = 1'b1;
        end
        default: begin
          next_pc_c = pc + 32'd4;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Hardware program launcher and PC sequencer for the instruction ROM.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  prog_sel,
  input  logic        stall,
  input  logic [2:0]  pcsel,
  input  logic [31:0] br_tgt,
  input  logic [31:0] jmp_tgt,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] xp,
  output logic        xp_we,
  output logic        busy,
  output logic        done,
  output logic        bad_sel
);

  fs_state_e   state;
  logic [31:0] base_q;
  logic [31:0] next_pc_c;
  logic        trap_c;
  logic        complete_c;

  fetch_sequencer_pc_next_mux u_mux (
    .pc         (pc),
    .pcsel      (pcsel),
    .br_tgt     (br_tgt),
    .jmp_tgt    (jmp_tgt),
    .irq        (irq),
    .next_pc_c  (next_pc_c),
    .trap_c     (trap_c),
    .complete_c (complete_c)
  );

  // Launch/run/complete FSM; strobes default low and are set only on their edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FS_IDLE;
      base_q  <= '0;
      pc      <= '0;
      xp      <= '0;
      xp_we   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bad_sel <= 1'b0;
    end else begin
      xp_we   <= 1'b0;
      done    <= 1'b0;
      bad_sel <= 1'b0;
      case (state)
        FS_IDLE: begin
          pc   <= '0;
          busy <= 1'b0;
          if (start) begin
            if (prog_valid(prog_sel)) begin
              base_q <= prog_base(prog_sel);
              state  <= FS_LAUNCH;
              busy   <= 1'b1;
            end else begin
              bad_sel <= 1'b1;
            end
          end
        end
        FS_LAUNCH: begin
          pc    <= base_q;
          state <= FS_RUN;
          busy  <= 1'b1;
        end
        FS_RUN: begin
          if (!stall) begin
            if (complete_c) begin
              pc    <= '0;
              state <= FS_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc <= next_pc_c;
              if (trap_c) begin
                xp    <= pc + 32'd4;
                xp_we <= 1'b1;
              end
            end
          end
        end
        FS_DONE: begin
          pc    <= '0;
          state <= FS_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, irq;
  logic [2:0]  prog_sel, pcsel;
  logic [31:0] br_tgt, jmp_tgt;
  logic [31:0] pc, xp;
  logic        xp_we, busy, done, bad_sel;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .stall(stall),
    .pcsel(pcsel), .br_tgt(br_tgt), .jmp_tgt(jmp_tgt), .irq(irq),
    .pc(pc), .xp(xp), .xp_we(xp_we), .busy(busy), .done(done), .bad_sel(bad_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: mode of the launcher plus architectural registers.
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_DONE = 3;
  int          m_mode = M_IDLE;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc = 0, m_xp = 0, m_base = 0;
  logic        m_xp_we = 0, m_done = 0, m_bad = 0, m_busy = 0;

  function automatic logic [31:0] base_of(input logic [2:0] s);
    case (s)
      3'd1: return 32'd80;
      3'd2: return 32'd120;
      3'd3: return 32'd320;
      default: return 32'd400;
    endcase
  endfunction

  task automatic model_step();
    int eff;
    logic [31:0] t;
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_xp = 0;
      m_xp_we = 0; m_done = 0; m_bad = 0; m_busy = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_xp_we = 0; m_bad = 0;
      case (m_mode)
        M_IDLE: if (start) begin
          if (prog_sel >= 3'd1 && prog_sel <= 3'd4) begin
            m_base = base_of(prog_sel); m_mode = M_LAUNCH;
          end else m_bad = 1;
        end
        M_LAUNCH: begin m_pc = m_base; m_mode = M_RUN; end
        M_RUN: if (!stall) begin
          eff = (pcsel > 3'd4) ? 0 : int'(pcsel);
          if ((irq && !m_pc[31]) || eff == 4) begin
            m_xp = m_pc + 32'd4; m_xp_we = 1; m_pc = 32'd504;
          end else if (eff == 3) begin
            m_xp = m_pc + 32'd4; m_xp_we = 1; m_pc = 32'd508;
          end else if (eff == 2) begin
            if ((jmp_tgt >> 2) == 0) begin
              m_pc = 0; m_mode = M_DONE;
            end else begin
              t = jmp_tgt & 32'hFFFF_FFFC;
              if (!m_pc[31]) t = t & 32'h7FFF_FFFF;
              m_pc = t;
            end
          end else if (eff == 1) begin
            m_pc = br_tgt | (m_pc & 32'h8000_0000);
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
        default: begin m_pc = 0; m_mode = M_IDLE; end
      endcase
      m_busy = (m_mode == M_LAUNCH) || (m_mode == M_RUN);
      m_done = (m_mode == M_DONE);
    end
  endtask

  // Single compare process: advance the model on each edge, then check every output.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("xp", xp, m_xp);
      chk("xp_we", 32'(xp_we), 32'(m_xp_we));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("bad_sel", 32'(bad_sel), 32'(m_bad));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic launch(input logic [2:0] s);
    start = 1; prog_sel = s; cyc();
    start = 0; cyc();
  endtask

  initial begin
    rst = 1; start = 0; prog_sel = 0; stall = 0; pcsel = 0;
    br_tgt = 0; jmp_tgt = 0; irq = 0;

    // 1: reset, start during reset must not launch
    start = 1; prog_sel = 3'd1;
    cyc(); cyc();
    chk("rst_pc", pc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 0; start = 0;
    cyc();
    chk("no_launch_in_rst", 32'(busy), 32'd0);

    // 2: launch program 1, sequential fetch
    launch(3'd1);
    chk("launch_pc", pc, 32'd80);
    chk("launch_busy", 32'(busy), 32'd1);
    cyc(); chk("inc1", pc, 32'd84);
    cyc(); chk("inc2", pc, 32'd88);
    cyc(); chk("inc3", pc, 32'd92);
    cyc(); cyc(); chk("at100", pc, 32'd100);

    // 3: branch then jump-to-0 completion
    pcsel = 3'd1; br_tgt = 32'd92; cyc();
    chk("branch", pc, 32'd92);
    pcsel = 3'd2; jmp_tgt = 32'd0; cyc();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_pc", pc, 32'd0);
    pcsel = 3'd0; cyc();
    chk("done_once", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 4: invalid program numbers
    start = 1; prog_sel = 3'd0; cyc();
    chk("bad0", 32'(bad_sel), 32'd1);
    start = 0; cyc();
    chk("bad0_clear", 32'(bad_sel), 32'd0);
    chk("bad0_idle", 32'(busy), 32'd0);
    start = 1; prog_sel = 3'd6; cyc();
    chk("bad6", 32'(bad_sel), 32'd1);
    start = 0; cyc();
    chk("bad6_pc", pc, 32'd0);

    // 5: interrupt trap, supervisor mode masks irq, wrap is not completion
    launch(3'd3);
    chk("launch3", pc, 32'd320);
    pcsel = 3'd1; br_tgt = 32'd200; cyc();
    pcsel = 3'd0; irq = 1; cyc();
    chk("irq_pc", pc, 32'd504);
    chk("irq_xp", xp, 32'd204);
    chk("irq_we", 32'(xp_we), 32'd1);
    irq = 0; cyc();
    chk("irq_we_once", 32'(xp_we), 32'd0);
    pcsel = 3'd1; br_tgt = 32'h8000_0100; cyc();
    pcsel = 3'd0; irq = 1; cyc();
    chk("super_inc", pc, 32'h8000_0104);
    chk("super_no_we", 32'(xp_we), 32'd0);
    irq = 0; pcsel = 3'd1; br_tgt = 32'hFFFF_FFFC; cyc();
    pcsel = 3'd0; cyc();
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_not_done", 32'(done), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd1);
    pcsel = 3'd2; jmp_tgt = 32'd3; cyc();
    chk("jmp3_done", 32'(done), 32'd1);
    pcsel = 3'd0; cyc();

    // 6: stall holds pc and ignores start, then reset mid-run
    launch(3'd2); cyc();
    chk("at124", pc, 32'd124);
    stall = 1; pcsel = 3'd1; br_tgt = 32'd400; start = 1; prog_sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", pc, 32'd124);
    end
    stall = 0; start = 0; cyc();
    chk("stall_release", pc, 32'd400);
    pcsel = 3'd0; rst = 1; cyc();
    chk("midrun_rst_pc", pc, 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    rst = 0;

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      int r;
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 5) == 0);
      prog_sel = 3'($urandom_range(0, 7));
      stall    = ($urandom_range(0, 4) == 0);
      irq      = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3, 4: pcsel = 3'd0;
        5:  pcsel = 3'd1;
        6:  pcsel = 3'd2;
        7:  pcsel = 3'd3;
        8:  pcsel = 3'd4;
        9:  pcsel = 3'($urandom_range(5, 7));
        default: pcsel = 3'd1;
      endcase
      br_tgt  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 127)) << 2;
      case ($urandom_range(0, 3))
        0: jmp_tgt = 32'($urandom_range(0, 3));
        1: jmp_tgt = $urandom();
        default: jmp_tgt = 32'($urandom_range(1, 127)) << 2;
      endcase
      cyc();
    end
    rst = 1; cyc(); rst = 0; cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
